// File: rtl/led_mode_ctrl.sv
// Multi-channel LED mode controller: synchronised, debounced buttons advance each
// channel OFF -> ON -> BLINK -> RAPID -> OFF; lit channels are PWM-dimmed and gated by a global enable.
module led_mode_ctrl #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 26,
  parameter int SLOW_BIT  = 25,
  parameter int FAST_BIT  = 24,
  parameter int PWM_W     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     btn_adv,
  input  logic                btn_en,
  input  logic [PWM_W-1:0]    duty,
  output logic [N_CH-1:0]     led,
  output logic [2*N_CH-1:0]   mode,
  output logic                en
);

  // The enable button rides along as the top bit of the button vector.
  localparam int NB   = N_CH + 1;
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ON    = 2'b01,
    ST_BLINK = 2'b10,
    ST_RAPID = 2'b11
  } state_t;

  logic [NB-1:0]    w_btn;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_db;
  logic [NB-1:0]    r_db_q;
  logic [NB-1:0]    w_pulse;
  logic [DB_W-1:0]  r_db_cnt [NB];

  state_t           r_state [N_CH];
  logic [CNT_W-1:0] r_blink [N_CH];
  logic [PWM_W-1:0] r_pwm;
  logic             r_en;
  logic [N_CH-1:0]  r_led;
  logic [N_CH-1:0]  w_lit;
  logic             w_pwm_on;

  assign w_btn    = {btn_en, btn_adv};
  assign w_pulse  = r_db & ~r_db_q;
  assign w_pwm_on = (duty == '1) || (r_pwm < duty);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      // NOTE: the debounce counter array is reset explicitly so a press interrupted by reset restarts cleanly.
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // NOTE: outputs of always_comb get a default first so no path can infer a latch.
  always_comb begin
    w_lit = '0;
    mode  = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode[2*i +: 2] = r_state[i];
      case (r_state[i])
        ST_ON:    w_lit[i] = 1'b1;
        ST_BLINK: w_lit[i] = r_blink[i][SLOW_BIT];
        ST_RAPID: w_lit[i] = r_blink[i][FAST_BIT];
        default:  w_lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= '0;
      r_en  <= 1'b1;
      r_led <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= ST_OFF;
        r_blink[i] <= '0;
      end
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (w_pulse[N_CH]) r_en <= ~r_en;
      for (int i = 0; i < N_CH; i++) begin
        if (w_pulse[i]) r_state[i] <= state_t'(r_state[i] + 2'd1);
        // Restart the counter on entry to a blinking state so the first phase is dark.
        if (w_pulse[i] && (r_state[i] == ST_ON || r_state[i] == ST_BLINK))
          r_blink[i] <= '0;
        else
          r_blink[i] <= r_blink[i] + 1'b1;
      end
      r_led <= {N_CH{r_en}} & w_lit & {N_CH{w_pwm_on}};
    end
  end

  assign led = r_led;
  assign en  = r_en;

endmodule
